// File: rtl/sensor_packet_buffer.sv
// sensor_packet_buffer
// Store-and-forward buffer for framed sensor packets. A packet starts with
// HEADER_VALUE and ends with a FOOTER_VALUE beat that has tlast set. Only
// complete, well-formed packets are released downstream. Malformed,
// oversize or overflowing packets are rolled back and counted as drops.
// The input never applies back-pressure.
//
// Ports:
//   master_clock   - sole clock
//   reset          - asynchronous, active-high reset
//   s_data_*       - AXIS input (tdata/tvalid/tlast); tready is 1 out of reset
//   m_data_*       - AXIS output (tdata/tvalid/tlast), m_data_tready input
//   good_count     - committed packets (saturating)
//   drop_count     - dropped packets (saturating)
//   fill_level     - committed words not yet consumed downstream
//   overflow_flag  - sticky: a drop was caused by a full buffer
//   dbg_state      - write FSM state (0 IDLE, 1 BODY, 2 DROP)
module sensor_packet_buffer #(
  parameter int          ADDR_WIDTH   = 11,
  parameter int          MAX_WORDS    = 1027,
  parameter logic [31:0] HEADER_VALUE = 32'hAAAAAAAA,
  parameter logic [31:0] FOOTER_VALUE = 32'h55555555
) (
  input  logic                  master_clock,
  input  logic                  reset,
  input  logic [31:0]           s_data_tdata,
  input  logic                  s_data_tvalid,
  input  logic                  s_data_tlast,
  output logic                  s_data_tready,
  output logic [31:0]           m_data_tdata,
  output logic                  m_data_tvalid,
  output logic                  m_data_tlast,
  input  logic                  m_data_tready,
  output logic [15:0]           good_count,
  output logic [15:0]           drop_count,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow_flag,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int CW    = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [32:0]   mem [DEPTH];
  logic [32:0]   ram_q_r;
  state_t        state_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] committed_wr_r;
  logic [PW-1:0] raddr_r;      // next RAM read address (prefetch side)
  logic [PW-1:0] rd_ptr_r;     // advances on downstream handshakes only
  logic [CW-1:0] word_cnt_r;
  logic          ram_vld_r;
  logic          hdr_s, ftr_s, full_s, oversize_s, wr_en_s;
  logic          out_free_s, s1_move_s, rd_issue_s;

  // Framing and space decode for the current input beat.
  assign hdr_s      = (s_data_tdata == HEADER_VALUE);
  assign ftr_s      = (s_data_tdata == FOOTER_VALUE);
  // Uses the consumption pointer, so a simultaneous read is not credited yet.
  assign full_s     = ((wr_ptr_r - rd_ptr_r) == PW'(DEPTH));
  assign oversize_s = (word_cnt_r == CW'(MAX_WORDS)) && !s_data_tlast;

  // RAM write enable for beats that are stored.
  always_comb begin
    wr_en_s = 1'b0;
    if (s_data_tvalid) begin
      case (state_r)
        ST_IDLE: wr_en_s = hdr_s && !s_data_tlast;
        ST_BODY: wr_en_s = !full_s && !oversize_s && (!s_data_tlast || ftr_s);
        default: wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Two-stage read pipeline: RAM output register, then AXIS output register.
  assign out_free_s = !m_data_tvalid || m_data_tready;
  assign s1_move_s  = ram_vld_r && out_free_s;
  assign rd_issue_s = (raddr_r != committed_wr_r) && (!ram_vld_r || s1_move_s);

  // Packet storage: synchronous write and registered read.
  always_ff @(posedge master_clock) begin
    if (wr_en_s) begin
      mem[wr_ptr_r[ADDR_WIDTH-1:0]] <= {s_data_tlast, s_data_tdata};
    end
    if (rd_issue_s) begin
      ram_q_r <= mem[raddr_r[ADDR_WIDTH-1:0]];
    end
  end

  // Write FSM: framing check, speculative write, commit or rollback.
  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      wr_ptr_r       <= '0;
      committed_wr_r <= '0;
      word_cnt_r     <= '0;
      good_count     <= 16'd0;
      drop_count     <= 16'd0;
      overflow_flag  <= 1'b0;
    end else if (s_data_tvalid) begin
      case (state_r)
        ST_IDLE: begin
          if (hdr_s && !s_data_tlast) begin
            wr_ptr_r   <= wr_ptr_r + PW'(1);
            word_cnt_r <= CW'(1);
            state_r    <= ST_BODY;
          end else begin
            drop_count <= sat_inc(drop_count);
            state_r    <= s_data_tlast ? ST_IDLE : ST_DROP;
          end
        end
        ST_BODY: begin
          if (full_s || oversize_s) begin
            wr_ptr_r   <= committed_wr_r;
            drop_count <= sat_inc(drop_count);
            if (full_s) begin
              overflow_flag <= 1'b1;
            end
            state_r <= s_data_tlast ? ST_IDLE : ST_DROP;
          end else if (s_data_tlast && ftr_s) begin
            wr_ptr_r       <= wr_ptr_r + PW'(1);
            committed_wr_r <= wr_ptr_r + PW'(1);
            good_count     <= sat_inc(good_count);
            state_r        <= ST_IDLE;
          end else if (s_data_tlast) begin
            wr_ptr_r   <= committed_wr_r;
            drop_count <= sat_inc(drop_count);
            state_r    <= ST_IDLE;
          end else begin
            wr_ptr_r   <= wr_ptr_r + PW'(1);
            word_cnt_r <= word_cnt_r + CW'(1);
          end
        end
        ST_DROP: begin
          if (s_data_tlast) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Read side: prefetch address, pipeline valids and AXIS output register.
  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      raddr_r       <= '0;
      rd_ptr_r      <= '0;
      ram_vld_r     <= 1'b0;
      m_data_tvalid <= 1'b0;
      m_data_tdata  <= 32'd0;
      m_data_tlast  <= 1'b0;
    end else begin
      if (rd_issue_s) begin
        raddr_r <= raddr_r + PW'(1);
      end
      if (rd_issue_s) begin
        ram_vld_r <= 1'b1;
      end else if (s1_move_s) begin
        ram_vld_r <= 1'b0;
      end
      if (s1_move_s) begin
        m_data_tvalid <= 1'b1;
        m_data_tdata  <= ram_q_r[31:0];
        m_data_tlast  <= ram_q_r[32];
      end else if (m_data_tvalid && m_data_tready) begin
        m_data_tvalid <= 1'b0;
      end
      if (m_data_tvalid && m_data_tready) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  assign s_data_tready = ~reset;
  assign fill_level    = committed_wr_r - rd_ptr_r;
  assign dbg_state     = state_r;

endmodule

// File: tb/tb_sensor_packet_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for sensor_packet_buffer: words of packets expected to be
// committed are queued when driven and compared as they leave m_data.
module tb_sensor_packet_buffer;

  localparam logic [31:0] HDR = 32'hAAAAAAAA;
  localparam logic [31:0] FTR = 32'h55555555;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_tdata = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [15:0] good_count, drop_count;
  logic [11:0] fill_level;
  logic        overflow_flag;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          failures = 0;
  int          rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
  logic [32:0] sb [$];
  logic [31:0] pd [$];
  logic        pl [$];
  logic        held = 1'b0;
  logic [32:0] held_word = 33'd0;

  sensor_packet_buffer dut (
    .master_clock (clk),
    .reset        (reset),
    .s_data_tdata (s_tdata),
    .s_data_tvalid(s_tvalid),
    .s_data_tlast (s_tlast),
    .s_data_tready(s_tready),
    .m_data_tdata (m_tdata),
    .m_data_tvalid(m_tvalid),
    .m_data_tlast (m_tlast),
    .m_data_tready(m_tready),
    .good_count   (good_count),
    .drop_count   (drop_count),
    .fill_level   (fill_level),
    .overflow_flag(overflow_flag),
    .dbg_state    (dbg_state)
  );

  always #12.5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      held <= 1'b0;
    end else begin
      if (held && m_tvalid) begin
        check_val("stall_stable", 64'({m_tlast, m_tdata}), 64'(held_word));
      end
      if (m_tvalid && m_tready) begin
        check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          check_val("out_word", 64'({m_tlast, m_tdata}), 64'(sb[0]));
          void'(sb.pop_front());
        end
      end
      held      <= m_tvalid && !m_tready;
      held_word <= {m_tlast, m_tdata};
    end
  end

  task automatic beat(input logic [31:0] d, input logic l);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] d, input logic l);
    pd.push_back(d);
    pl.push_back(l);
  endtask

  // Header, timestamp, n payload words (random or index pattern), footer.
  task automatic build(input int n, input bit raw);
    logic [10:0] idx;
    pd.delete();
    pl.delete();
    add(HDR, 1'b0);
    add(32'h10, 1'b0);
    for (int i = 0; i < n; i++) begin
      idx = 11'(i);
      if (raw) add({10'd0, idx, idx}, 1'b0);
      else     add($urandom, 1'b0);
    end
    add(FTR, 1'b1);
  endtask

  task automatic drive_pkt(input bit good);
    if (good) begin
      for (int i = 0; i < pd.size(); i++) sb.push_back({pl[i], pd[i]});
    end
    for (int i = 0; i < pd.size(); i++) beat(pd[i], pl[i]);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_left", 64'(sb.size()), 64'd0);
    idle(4);
  endtask

  initial begin
    // Reset state.
    #3;
    check_val("rst_tready", 64'(s_tready), 64'd0);
    check_val("rst_mvalid", 64'(m_tvalid), 64'd0);
    check_val("rst_fill", 64'(fill_level), 64'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    check_val("tready_on", 64'(s_tready), 64'd1);

    // 1: full-size raw packet and output latency.
    rdy_mode = 1;
    build(1024, 1'b1);
    drive_pkt(1'b1);
    @(negedge clk);
    check_val("lat_n0", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    check_val("lat_n1", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    check_val("lat_n2_valid", 64'(m_tvalid), 64'd1);
    check_val("lat_n2_hdr", 64'(m_tdata), 64'(HDR));
    wait_drain(2000);
    check_val("t1_good", 64'(good_count), 64'd1);
    check_val("t1_drop", 64'(drop_count), 64'd0);

    // 2: bad footer, then a good 6-word packet.
    pd.delete(); pl.delete();
    add(HDR, 1'b0); add(32'h1, 1'b0); add(32'h2, 1'b0); add(32'h12345678, 1'b1);
    drive_pkt(1'b0);
    idle(4);
    check_val("t2_fill", 64'(fill_level), 64'd0);
    check_val("t2_drop", 64'(drop_count), 64'd1);
    check_val("t2_nout", 64'(m_tvalid), 64'd0);
    build(3, 1'b0);
    drive_pkt(1'b1);
    wait_drain(100);
    check_val("t2_good", 64'(good_count), 64'd2);

    // 3: stalled output, second packet overflows.
    rdy_mode = 0;
    idle(1);
    build(1024, 1'b0);
    drive_pkt(1'b1);
    idle(4);
    check_val("t3_fill", 64'(fill_level), 64'd1027);
    check_val("t3_ovf_pre", 64'(overflow_flag), 64'd0);
    build(1024, 1'b0);
    drive_pkt(1'b0);
    idle(4);
    check_val("t3_ovf", 64'(overflow_flag), 64'd1);
    check_val("t3_drop", 64'(drop_count), 64'd2);
    check_val("t3_fill2", 64'(fill_level), 64'd1027);
    rdy_mode = 1;
    wait_drain(2000);
    idle(10);
    check_val("t3_mvalid", 64'(m_tvalid), 64'd0);
    check_val("t3_good", 64'(good_count), 64'd3);

    // 4: 1030-word packet is oversize.
    build(1027, 1'b0);
    drive_pkt(1'b0);
    idle(6);
    check_val("t4_drop", 64'(drop_count), 64'd3);
    check_val("t4_fill", 64'(fill_level), 64'd0);
    check_val("t4_state", 64'(dbg_state), 64'd0);
    check_val("t4_nout", 64'(m_tvalid), 64'd0);

    // 5: stream joined mid-packet, then a good packet.
    pd.delete(); pl.delete();
    add(32'h00000123, 1'b0); add(32'h7, 1'b0); add(FTR, 1'b1);
    drive_pkt(1'b0);
    build(5, 1'b0);
    drive_pkt(1'b1);
    wait_drain(100);
    check_val("t5_drop", 64'(drop_count), 64'd4);
    check_val("t5_good", 64'(good_count), 64'd4);

    // 6: random ready over 20 packets, then reset mid-packet.
    rdy_mode = 2;
    for (int p = 0; p < 20; p++) begin
      build(int'($urandom_range(0, 30)), 1'b0);
      drive_pkt(1'b1);
      idle(int'($urandom_range(0, 3)));
    end
    wait_drain(3000);
    check_val("t6_good", 64'(good_count), 64'd24);
    build(20, 1'b0);
    for (int i = 0; i < 11; i++) beat(pd[i], pl[i]);
    check_val("t6_body", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    #2;
    check_val("t6_rst_tready", 64'(s_tready), 64'd0);
    check_val("t6_rst_state", 64'(dbg_state), 64'd0);
    check_val("t6_rst_ovf", 64'(overflow_flag), 64'd0);
    check_val("t6_rst_good", 64'(good_count), 64'd0);
    check_val("t6_rst_drop", 64'(drop_count), 64'd0);
    check_val("t6_rst_fill", 64'(fill_level), 64'd0);
    check_val("t6_rst_mout", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
    sb.delete();
    idle(2);
    reset = 1'b0;
    rdy_mode = 1;
    idle(2);
    build(4, 1'b0);
    drive_pkt(1'b1);
    wait_drain(100);
    check_val("t6_post_good", 64'(good_count), 64'd1);
    check_val("t6_post_drop", 64'(drop_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
